scram_seq_gen: RTL and testbench

SCRAM_SEQ_GEN -- requirements
Module: scram_seq_gen

---
 rtl/scram_seq_gen.sv | 148 ++++++++++++++
 tb/tb_scram_seq_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scram_seq_gen.sv
// rtl/scram_seq_gen.sv - Gold-style scrambling sequence generator with warm-up and PAR-bit beats
module scram_seq_gen #(
   parameter int                  LFSR_WIDTH = 31,
   parameter logic [LFSR_WIDTH-1:0] X1_TAPS  = 31'h0000_0009,
   parameter logic [LFSR_WIDTH-1:0] X2_TAPS  = 31'h0000_000F,
   parameter logic [LFSR_WIDTH-1:0] X1_INIT  = 31'h0000_0001,
   parameter int                  NC         = 1600,
   parameter int                  PAR        = 8,
   parameter int                  LEN_W      = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [LFSR_WIDTH-1:0] c_init,
   input  logic [LEN_W-1:0]      seq_len,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic [PAR-1:0]        out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   localparam int WU_CNT = NC / PAR;
   localparam int WU_W   = (WU_CNT > 1) ? $clog2(WU_CNT) : 1;
   localparam logic [WU_W-1:0] WU_LAST = WU_W'((WU_CNT > 0) ? WU_CNT - 1 : 0);

   typedef enum logic [1:0] {IDLE, WARMUP, OUTPUT, DONE} state_t;

   state_t                  state_q, state_d;
   logic [LFSR_WIDTH-1:0]   x1_q, x1_d, x2_q, x2_d;
   logic [LFSR_WIDTH-1:0]   x1_adv, x2_adv;
   logic [LEN_W-1:0]        rem_q, rem_d;
   logic [WU_W-1:0]         wu_q, wu_d;
   logic                    out_valid_q, out_valid_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [PAR-1:0]          data_raw;
   logic [PAR-1:0]          data_mask;
   logic                    last_beat;

   // One Fibonacci step: parity of tapped bits enters the MSB, register shifts right.
   function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] r,
                                                       input logic [LFSR_WIDTH-1:0] taps);
      return {^(r & taps), r[LFSR_WIDTH-1:1]};
   endfunction

   // PAR-step look-ahead: the beat bits and the state after a full beat of steps.
   always_comb begin
      logic [LFSR_WIDTH-1:0] t1, t2;
      t1       = x1_q;
      t2       = x2_q;
      data_raw = '0;
      for (int i = 0; i < PAR; i++) begin
         data_raw[i] = t1[0] ^ t2[0];
         t1 = lfsr_step(t1, X1_TAPS);
         t2 = lfsr_step(t2, X2_TAPS);
      end
      x1_adv = t1;
      x2_adv = t2;
   end

   // Zero the bit positions beyond the remaining count so a short final beat is padded.
   always_comb begin
      data_mask = '0;
      for (int i = 0; i < PAR; i++) begin
         data_mask[i] = (LEN_W'(i) < rem_q);
      end
   end

   assign last_beat = (rem_q <= LEN_W'(PAR));

   // Next-state logic for the sequencer; LFSRs only move in WARMUP or on an accepted beat.
   always_comb begin
      state_d = state_q;
      x1_d    = x1_q;
      x2_d    = x2_q;
      rem_d   = rem_q;
      wu_d    = wu_q;
      case (state_q)
         IDLE: begin
            if (start && (seq_len != '0)) begin
               x1_d    = X1_INIT;
               x2_d    = c_init;
               rem_d   = seq_len;
               wu_d    = '0;
               state_d = (WU_CNT > 0) ? WARMUP : OUTPUT;
            end
         end
         WARMUP: begin
            x1_d = x1_adv;
            x2_d = x2_adv;
            wu_d = wu_q + WU_W'(1);
            if (wu_q == WU_LAST) begin
               state_d = OUTPUT;
            end
         end
         OUTPUT: begin
            if (out_ready) begin
               x1_d = x1_adv;
               x2_d = x2_adv;
               if (last_beat) begin
                  rem_d   = '0;
                  state_d = DONE;
               end else begin
                  rem_d = rem_q - LEN_W'(PAR);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      out_valid_d = (state_d == OUTPUT);
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == DONE);
   end

   // State and output registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         x1_q        <= '0;
         x2_q        <= '0;
         rem_q       <= '0;
         wu_q        <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x1_q        <= x1_d;
         x2_q        <= x2_d;
         rem_q       <= rem_d;
         wu_q        <= wu_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign out_last  = out_valid_q & last_beat;
   assign out_data  = out_valid_q ? (data_raw & data_mask) : '0;

endmodule

// File: tb/tb_scram_seq_gen.sv
// tb/tb_scram_seq_gen.sv - scoreboard bench for scram_seq_gen
module tb_scram_seq_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start0;
   logic [30:0] c_init, c_init0;
   logic [11:0] seq_len, seq_len0;
   logic        out_ready, out_ready0;
   logic        out_valid, out_valid0;
   logic [7:0]  out_data, out_data0;
   logic        out_last, out_last0;
   logic        busy, busy0;
   logic        done, done0;

   int checks   = 0;
   int failures = 0;

   logic [8:0] exp_q[$];
   logic [8:0] exp0_q[$];
   int         beats_cnt = 0, beats0_cnt = 0;
   int         done_cnt = 0, done0_cnt = 0;
   logic [7:0] last_data;
   logic       last_flag;
   logic       stalled = 1'b0;
   logic [7:0] hold_data;
   logic       hold_last;

   scram_seq_gen dut (
      .clk(clk), .rst(rst), .start(start), .c_init(c_init), .seq_len(seq_len),
      .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
      .out_last(out_last), .busy(busy), .done(done)
   );

   scram_seq_gen #(.NC(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .c_init(c_init0), .seq_len(seq_len0),
      .out_ready(out_ready0), .out_valid(out_valid0), .out_data(out_data0),
      .out_last(out_last0), .busy(busy0), .done(done0)
   );

   always #5 clk = ~clk;

   task automatic check(input bit ok, input string name, input int act, input int exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Bit-serial reference: one step at a time, beats assembled LSB first.
   task automatic push_model(input logic [30:0] ci, input int len, input int nc, input bit which);
      logic [30:0] x1, x2;
      logic [7:0]  d;
      int          nb;
      x1 = 31'h1;
      x2 = ci;
      for (int s = 0; s < nc; s++) begin
         x1 = {^(x1 & 31'h9), x1[30:1]};
         x2 = {^(x2 & 31'hF), x2[30:1]};
      end
      nb = (len + 7) / 8;
      for (int k = 0; k < nb; k++) begin
         d = 8'h00;
         for (int i = 0; i < 8; i++) begin
            if (k * 8 + i < len) d[i] = x1[0] ^ x2[0];
            x1 = {^(x1 & 31'h9), x1[30:1]};
            x2 = {^(x2 & 31'hF), x2[30:1]};
         end
         if (which) exp0_q.push_back({(k == nb - 1), d});
         else       exp_q.push_back({(k == nb - 1), d});
      end
   endtask

   // Monitor for the default-parameter instance.
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst) begin
         exp_q.delete();
         stalled = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (out_valid) begin
            if (stalled)
               check({out_last, out_data} == {hold_last, hold_data}, "stall_hold",
                     {out_last, out_data}, {hold_last, hold_data});
            if (out_ready) begin
               stalled = 1'b0;
               if (exp_q.size() == 0) begin
                  check(1'b0, "unexpected_beat", {out_last, out_data}, 0);
               end else begin
                  e = exp_q.pop_front();
                  check({out_last, out_data} == e, "beat", {out_last, out_data}, e);
               end
               beats_cnt++;
               last_data = out_data;
               last_flag = out_last;
            end else begin
               stalled   = 1'b1;
               hold_data = out_data;
               hold_last = out_last;
            end
         end else if (out_data != 8'h00 || out_last) begin
            check(1'b0, "idle_outputs", {out_last, out_data}, 0);
         end
      end
   end

   // Monitor for the NC=0 instance.
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst) begin
         exp0_q.delete();
      end else begin
         if (done0) done0_cnt++;
         if (out_valid0 && out_ready0) begin
            if (exp0_q.size() == 0) begin
               check(1'b0, "unexpected_beat0", {out_last0, out_data0}, 0);
            end else begin
               e = exp0_q.pop_front();
               check({out_last0, out_data0} == e, "beat0", {out_last0, out_data0}, e);
            end
            beats0_cnt++;
         end
      end
   end

   // Pulse start for one cycle; n = edges from the accepting edge to first out_valid.
   task automatic start_seq(input bit which, input logic [30:0] ci, input logic [11:0] len,
                            input bit wait_valid, output int n);
      @(posedge clk); #1;
      if (which) begin start0 = 1'b1; c_init0 = ci; seq_len0 = len; end
      else       begin start  = 1'b1; c_init  = ci; seq_len  = len; end
      @(posedge clk); #1;
      start = 1'b0; start0 = 1'b0;
      n = 0;
      if (wait_valid) begin
         while (!(which ? out_valid0 : out_valid) && n < 1000) begin
            @(posedge clk); #1; n++;
         end
         check(n < 1000, "valid_timeout", n, 1000);
      end
   endtask

   // Wait for done; n = edges counted from the call point.
   task automatic wait_done(input bit which, input bit rnd, output int n);
      n = 0;
      while (!(which ? done0 : done) && n < 3000) begin
         @(posedge clk); #1; n++;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
      end
      check(n < 3000, "done_timeout", n, 3000);
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic check_zero_outputs(input string name);
      check({out_valid, out_data, out_last, busy, done} == 12'h0, name,
            {out_valid, out_data, out_last, busy, done}, 0);
   endtask

   task automatic run_ref();
      int lat, nd, b0, d0;
      b0 = beats_cnt; d0 = done_cnt;
      push_model(31'h1234567, 1920, 1600, 1'b0);
      start_seq(1'b0, 31'h1234567, 12'd1920, 1'b1, lat);
      check(lat == 200, "ref_latency", lat, 200);
      wait_done(1'b0, 1'b0, nd);
      check(lat + nd == 440, "ref_done_time", lat + nd, 440);
      check(beats_cnt - b0 == 240, "ref_beats", beats_cnt - b0, 240);
      check(done_cnt - d0 == 1, "ref_done_count", done_cnt - d0, 1);
      check(exp_q.size() == 0, "ref_queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      int lat, nd, b0, d0;
      rst = 1'b0; start = 1'b0; start0 = 1'b0;
      c_init = '0; c_init0 = '0; seq_len = '0; seq_len0 = '0;
      out_ready = 1'b1; out_ready0 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset_outputs");
      check({out_valid0, out_data0, out_last0, busy0, done0} == 12'h0, "reset_outputs0",
            {out_valid0, out_data0, out_last0, busy0, done0}, 0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("quiet_after_reset");

      // NC=0, c_init=0: hand-derived beats of the x1 sequence alone.
      exp0_q.push_back(9'h001);
      exp0_q.push_back(9'h000);
      exp0_q.push_back(9'h000);
      exp0_q.push_back(9'h180);
      b0 = beats0_cnt; d0 = done0_cnt;
      start_seq(1'b1, 31'h0, 12'd32, 1'b1, lat);
      check(lat == 0, "nc0_latency", lat, 0);
      wait_done(1'b1, 1'b0, nd);
      check(nd == 4, "nc0_done_time", nd, 4);
      check(beats0_cnt - b0 == 4, "nc0_beats", beats0_cnt - b0, 4);
      check(done0_cnt - d0 == 1, "nc0_done_count", done0_cnt - d0, 1);

      // Full-length reference stream.
      run_ref();

      // Random backpressure, short final beat.
      b0 = beats_cnt;
      push_model(31'h5A5A5A5, 100, 1600, 1'b0);
      start_seq(1'b0, 31'h5A5A5A5, 12'd100, 1'b0, lat);
      wait_done(1'b0, 1'b1, nd);
      check(beats_cnt - b0 == 13, "bp_beats", beats_cnt - b0, 13);
      check(last_data[7:4] == 4'h0, "bp_last_pad", last_data, 0);
      check(last_flag == 1'b1, "bp_last_flag", last_flag, 1);

      // Start pulses while busy must not disturb the running sequence.
      b0 = beats_cnt; d0 = done_cnt;
      push_model(31'h0ABCDEF, 160, 1600, 1'b0);
      start_seq(1'b0, 31'h0ABCDEF, 12'd160, 1'b0, lat);
      repeat (20) @(posedge clk);
      start_seq(1'b0, 31'h7FFFFFF, 12'd8, 1'b1, lat);
      @(posedge clk); #1;
      start_seq(1'b0, 31'h1111111, 12'd24, 1'b0, lat);
      wait_done(1'b0, 1'b0, nd);
      check(beats_cnt - b0 == 20, "busy_start_beats", beats_cnt - b0, 20);
      check(done_cnt - d0 == 1, "busy_start_done", done_cnt - d0, 1);

      // Zero-length start in IDLE is ignored.
      d0 = done_cnt;
      start_seq(1'b0, 31'h1234567, 12'd0, 1'b0, lat);
      check({busy, out_valid} == 2'b00, "zero_len_idle", {busy, out_valid}, 0);
      repeat (5) @(posedge clk);
      #1;
      check(done_cnt == d0, "zero_len_no_done", done_cnt - d0, 0);

      // Reset on the 50th warm-up cycle.
      d0 = done_cnt;
      push_model(31'h1234567, 1920, 1600, 1'b0);
      start_seq(1'b0, 31'h1234567, 12'd1920, 1'b0, lat);
      repeat (49) @(posedge clk);
      #2 rst = 1'b0;
      #1 check_zero_outputs("rst_warmup_outputs");
      @(posedge clk); #1 rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_zero_outputs("rst_warmup_quiet");
      check(done_cnt == d0, "rst_warmup_no_done", done_cnt - d0, 0);
      run_ref();

      // Reset while the 3rd output beat is presented.
      d0 = done_cnt; b0 = beats_cnt;
      push_model(31'h1234567, 1920, 1600, 1'b0);
      start_seq(1'b0, 31'h1234567, 12'd1920, 1'b1, lat);
      nd = 0;
      while (beats_cnt - b0 < 2 && nd < 100) begin
         @(posedge clk); #2; nd++;
      end
      check(beats_cnt - b0 == 2, "rst_output_position", beats_cnt - b0, 2);
      rst = 1'b0;
      #1 check_zero_outputs("rst_output_outputs");
      @(posedge clk); #1 rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_zero_outputs("rst_output_quiet");
      check(done_cnt == d0, "rst_output_no_done", done_cnt - d0, 0);
      run_ref();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=timeout expected=finish");
      $fatal(1, "timeout");
   end

endmodule
